half_adder_bist: RTL



---
 rtl/half_adder_bist_pkg.sv | 19 +
 rtl/bist_sat_counter.sv | 20 ++
 rtl/half_adder_bist.sv | 125 ++++++++++++
 3 files changed

// File: rtl/half_adder_bist_pkg.sv
// Shared types, constants and the golden half-adder model for the BIST controller.
package half_adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int VEC_W   = 2;
    localparam int NUM_VEC = 4;

    // Returns {sum, carry} of an ideal half adder.
    function automatic logic [1:0] expected_result(input logic a, input logic b);
        return {a ^ b, a & b};
    endfunction

endpackage

// File: rtl/bist_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear takes priority over increment.
module bist_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/half_adder_bist.sv
// Exhaustive-sweep self-test controller: drives a/b into the half adder, waits to settle,
// checks sum/carry and keeps a saturating error count plus the first failing observation.
module half_adder_bist
    import half_adder_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       first_fail,
    output logic             first_valid,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_sum,
    input  logic             dut_carry
);

    localparam int SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TOTAL_VEC   = NUM_VEC * PASSES;
    localparam int VW          = $clog2(TOTAL_VEC);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
    localparam logic [VW-1:0] LAST_VEC    = VW'(TOTAL_VEC - 1);

    state_t            state;
    state_t            state_next;
    logic [SW-1:0]     settle_cnt;
    logic [VW-1:0]     vec_cnt;
    logic [VW-1:0]     vec_cnt_inc;
    logic [1:0]        expected;
    logic              start_accept;
    logic              last_vec;
    logic              mismatch;

    assign start_accept = (state == IDLE) && start;
    assign last_vec     = (vec_cnt == LAST_VEC);
    assign vec_cnt_inc  = vec_cnt + VW'(1);
    assign expected     = expected_result(dut_a, dut_b);
    assign mismatch     = (state == CHECK) && ({dut_sum, dut_carry} != expected);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_next = CHECK;
            CHECK:   state_next = last_vec ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stimulus, settle timing and result capture; the low two bits of vec_cnt are {a,b}.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt  <= '0;
            vec_cnt     <= '0;
            dut_a       <= 1'b0;
            dut_b       <= 1'b0;
            pass        <= 1'b0;
            first_fail  <= '0;
            first_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        settle_cnt  <= SETTLE_INIT;
                        vec_cnt     <= '0;
                        dut_a       <= 1'b0;
                        dut_b       <= 1'b0;
                        pass        <= 1'b0;
                        first_fail  <= '0;
                        first_valid <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
                end
                CHECK: begin
                    if (mismatch && !first_valid) begin
                        first_fail  <= {dut_a, dut_b, dut_sum, dut_carry};
                        first_valid <= 1'b1;
                    end
                    if (last_vec) begin
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        vec_cnt    <= vec_cnt_inc;
                        dut_a      <= vec_cnt_inc[1];
                        dut_b      <= vec_cnt_inc[0];
                        settle_cnt <= SETTLE_INIT;
                    end
                end
                default: ;
            endcase
        end
    end

    bist_sat_counter #(
        .W (ERR_W)
    ) u_err_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (start_accept),
        .inc   (mismatch),
        .count (err_count)
    );

endmodule
